pe_acc: RTL and testbench
=========================

# pe_acc

Result accumulator directly downstream of a processing element. It consumes the PE's registered 16-bit product stream (`c1_vld`/`c1_data`) and sums a programmed number of products into one dot-product term. It saturates on overflow and presents the finished sum to the result-writeback logic over a valid/ready handshake. There is one instance per PE; sequencing comes from the array controller via `acc_start`.

## Interface
- `PROD_W`, 16: product width; matches PE `c1_data`.
- `ACC_W`, 24: accumulator and result width; must be greater than or equal to `PROD_W`.
- `LEN_W`, 8: width of the term count `acc_len`.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `acc_start`  in  1: single-cycle pulse that begins an accumulation.
- `acc_len`  in  `LEN_W`: number of products to sum; sampled only when `acc_start` is accepted.
- `acc_clr`  in  1: synchronous abort; returns the block to IDLE.
- `prod_vld`  in  1: product valid; driven from PE `c1_vld`.
- `prod_data`  in  `PROD_W`: unsigned product; driven from PE `c1_data`.
- `res_vld`  out  1: result valid.
- `res_data`  out  `ACC_W`: accumulated sum.
- `res_ovf`  out  1: the result saturated; qualified by `res_vld`.
- `res_rdy`  in  1: consumer accepts the result.
- `acc_busy`  out  1: high in ACC and DONE.
- `drop_err`  out  1: one-cycle pulse when a product arrives outside ACC.

## Operation
- **States:** IDLE, ACC, DONE. Reset state is IDLE.
- **IDLE:**
  - If `acc_start`: latch `acc_len` into `rem`, clear `acc` and `ovf`.
  - If `acc_len` ≠ 0, go to ACC.
  - If `acc_len` = 0, go to DONE with result 0 and `res_ovf` = 0.
- **ACC:**
  - On each `prod_vld`: `acc` ← sat(`acc` + zero-extended `prod_data`) and `rem` ← `rem` − 1.
  - When `rem` = 1 and `prod_vld`: the final sum loads `res_data` and the state goes to DONE.
  - Cycles without `prod_vld` stall; there is no timeout.
- **DONE:**
  - `res_vld` = 1 and `res_data`/`res_ovf` are held stable until `res_rdy`.
  - If `res_rdy` and not `acc_start`, go to IDLE.
  - If `res_rdy` and `acc_start` in the same cycle: back-to-back start. Latch the new `acc_len` and go to ACC, or stay in DONE with result 0 if `acc_len` = 0.
  - `acc_start` without `res_rdy` is ignored.
- **Saturation:** if the unsigned sum exceeds 2^`ACC_W`−1, `acc` clamps to all ones and the sticky `ovf` is set for the current accumulation. `res_ovf` = `ovf`.
- **Product outside ACC:** `prod_vld` in IDLE or DONE is discarded and `drop_err` pulses the next cycle. This includes a product in the same cycle as the accepted `acc_start`.
- **`acc_start` in ACC:** ignored, with no error flag.
- **`acc_clr`:** highest priority in every state. Next state is IDLE, `res_vld` goes to 0, `acc`/`rem`/`ovf` clear, and a product in the same cycle is discarded without `drop_err`.
- **`acc_busy`:** equals (state ≠ IDLE).

## Timing
- **Reset values:** `res_vld` 0, `res_data` 0, `res_ovf` 0, `acc_busy` 0, `drop_err` 0; internal `acc`, `rem`, `ovf` are 0.
- **Start:** `acc_start` at edge T puts the state in ACC from cycle T+1. The first product can be accepted in cycle T+1.
- **Result latency:** last product accepted in cycle N gives `res_vld` = 1 in cycle N+1. The block adds one cycle after PE `c1_vld`.
- **Handshake:** transfer occurs in the cycle where `res_vld` & `res_rdy` are both high. `res_vld` falls at the next edge unless a zero-length back-to-back start applies.
- **Throughput:** with `res_rdy` tied high, a length-L accumulation occupies L+1 cycles when back-to-back starts are used.
- **`drop_err`:** registered; asserted exactly one cycle per dropped product.
- **Reset mid-operation:** asynchronous return to IDLE with all outputs at their reset values immediately.

## Test plan
- **Basic sum:** `acc_len`=4, products 3, 5, 7, 9 on consecutive cycles → `res_vld` one cycle after the 4th product with `res_data`=24 and `res_ovf`=0; `res_rdy`=1 → IDLE and `acc_busy`=0 next cycle.
- **Stalls and backpressure:** `acc_len`=3, products 0xFFFF / gap of 2 cycles / 0x0001 / 0x0100, `res_rdy` low for 5 cycles → `res_data`=0x010100 held stable and `res_vld` held for the full 5 cycles.
- **Saturation:** `ACC_W`=16, `acc_len`=2, products 0xF000, 0x2000 → `res_data`=0xFFFF, `res_ovf`=1. The next accumulation of products 1, 1 gives `res_data`=2, `res_ovf`=0.
- **Zero length and back-to-back:**
  - `acc_len`=0 → `res_vld` at T+1 with `res_data`=0.
  - In DONE, `res_rdy` and `acc_start` with `acc_len`=2 together, then products 10, 20 → second result 30 with no idle cycle.
- **Errors:**
  - `prod_vld` in IDLE → `drop_err` pulses for 1 cycle and the next result is unaffected.
  - `acc_start` in ACC is ignored: the result counts only the original `acc_len`.
- **Abort and reset:**
  - `acc_clr` after 2 of 4 products → IDLE with `res_vld` never asserted; a new run with products 1, 2 (`acc_len`=2) gives 3.
  - `rst_n` low while in DONE → `res_vld`=0 immediately.

Source files
------------

// File: rtl/pe_acc.sv
// pe_acc: saturating dot-product accumulator behind one processing element.
// Sums acc_len unsigned products into an ACC_W result and hands it off over
// a valid/ready handshake. Product and drop flag positions are registered.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   acc_start, acc_len   begin an accumulation of acc_len products
//   acc_clr              synchronous abort back to IDLE
//   prod_vld, prod_data  product stream from the PE (c1_vld / c1_data)
//   res_vld, res_data    finished sum, held until res_rdy
//   res_ovf              sum saturated (qualified by res_vld)
//   res_rdy              consumer accepts the result
//   acc_busy             state is ACC or DONE
//   drop_err             one-cycle pulse per product seen outside ACC
module pe_acc #(
    parameter int PROD_W = 16,
    parameter int ACC_W  = 24,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              acc_start,
    input  logic [LEN_W-1:0]  acc_len,
    input  logic              acc_clr,
    input  logic              prod_vld,
    input  logic [PROD_W-1:0] prod_data,
    output logic              res_vld,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    input  logic              res_rdy,
    output logic              acc_busy,
    output logic              drop_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [ACC_W-1:0]   r_acc;
    logic [LEN_W-1:0]   r_rem;
    logic               r_ovf;
    logic               r_drop;

    logic               w_load;
    logic               w_take;
    logic               w_last;
    logic               w_len_zero;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic               w_drop_nxt;

    // A start is accepted in IDLE, or in DONE only together with the
    // handshake that retires the current result (back-to-back start).
    assign w_load     = acc_start &&
                        ((r_state == S_IDLE) ||
                         ((r_state == S_DONE) && res_rdy));
    assign w_take     = (r_state == S_ACC) && prod_vld;
    assign w_last     = w_take && (r_rem == LEN_W'(1));
    assign w_len_zero = (acc_len == '0);

    // One extra bit catches the unsigned carry out of the accumulator.
    assign w_sum   = {1'b0, r_acc} + (ACC_W + 1)'(prod_data);
    assign w_carry = w_sum[ACC_W];

    // Products outside ACC are dropped; an abort swallows them silently.
    assign w_drop_nxt = prod_vld && !acc_clr && (r_state != S_ACC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (acc_clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        w_state_nxt = w_len_zero ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_rdy) begin
                        if (w_load) begin
                            w_state_nxt = w_len_zero ? S_DONE : S_ACC;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // The accumulator itself is the result register: it stops changing
    // once the last product lands, so it is stable for the whole of DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_rem <= '0;
            r_ovf <= 1'b0;
        end else if (acc_clr) begin
            r_acc <= '0;
            r_rem <= '0;
            r_ovf <= 1'b0;
        end else if (w_load) begin
            r_acc <= '0;
            r_rem <= acc_len;
            r_ovf <= 1'b0;
        end else if (w_take) begin
            r_acc <= w_carry ? '1 : w_sum[ACC_W-1:0];
            r_ovf <= r_ovf | w_carry;
            r_rem <= r_rem - LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_drop_nxt;
        end
    end

    assign res_vld  = (r_state == S_DONE);
    assign res_data = r_acc;
    assign res_ovf  = r_ovf;
    assign acc_busy = (r_state != S_IDLE);
    assign drop_err = r_drop;

endmodule

// File: tb/tb_pe_acc.sv
// tb_pe_acc: vector table, directed corner sequences and random traffic
// for pe_acc at ACC_W=24 and ACC_W=16, both fed the same stimulus.
module tb_pe_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        clr = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] data = '0;
    logic        rdy = 1'b0;

    logic        v24, o24, b24, e24;
    logic [23:0] d24;
    logic        v16, o16, b16, e16;
    logic [15:0] d16;

    always #5 clk = ~clk;

    pe_acc #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) u_dut24 (
        .clk(clk), .rst_n(rst_n), .acc_start(start), .acc_len(len),
        .acc_clr(clr), .prod_vld(vld), .prod_data(data),
        .res_vld(v24), .res_data(d24), .res_ovf(o24), .res_rdy(rdy),
        .acc_busy(b24), .drop_err(e24)
    );

    pe_acc #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .acc_start(start), .acc_len(len),
        .acc_clr(clr), .prod_vld(vld), .prod_data(data),
        .res_vld(v16), .res_data(d16), .res_ovf(o16), .res_rdy(rdy),
        .acc_busy(b16), .drop_err(e16)
    );

    int nchk = 0;
    int nerr = 0;

    // Reference: 0 idle, 1 accumulating, 2 result pending.
    int     ms[2];
    longint macc[2];
    int     mrem[2];
    bit     movf[2];
    bit     mdrop[2];
    longint mmax[2];

    typedef struct {
        int     l;
        int     p[4];
        longint e24;
        bit     o24;
        longint e16;
        bit     o16;
    } vec_t;

    vec_t vq[$];

    task automatic chk(string name, longint act, longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; macc[i] = 0; mrem[i] = 0;
            movf[i] = 0; mdrop[i] = 0;
        end
    endtask

    task automatic mstep(int i);
        longint t;
        if (clr) begin
            ms[i] = 0; macc[i] = 0; mrem[i] = 0;
            movf[i] = 0; mdrop[i] = 0;
            return;
        end
        mdrop[i] = vld && (ms[i] != 1);
        if (ms[i] == 1) begin
            if (vld) begin
                t = macc[i] + longint'(data);
                if (t > mmax[i]) begin
                    macc[i] = mmax[i];
                    movf[i] = 1;
                end else begin
                    macc[i] = t;
                end
                mrem[i] = mrem[i] - 1;
                if (mrem[i] == 0) ms[i] = 2;
            end
        end else if (start && (ms[i] == 0 || rdy)) begin
            mrem[i] = int'(len);
            macc[i] = 0;
            movf[i] = 0;
            ms[i] = (len == 0) ? 2 : 1;
        end else if (ms[i] == 2 && rdy) begin
            ms[i] = 0;
        end
    endtask

    task automatic mcompare();
        chk("vld24", longint'(v24), longint'(ms[0] == 2));
        chk("busy24", longint'(b24), longint'(ms[0] != 0));
        chk("drop24", longint'(e24), longint'(mdrop[0]));
        if (ms[0] == 2) begin
            chk("data24", longint'(d24), macc[0]);
            chk("ovf24", longint'(o24), longint'(movf[0]));
        end
        chk("vld16", longint'(v16), longint'(ms[1] == 2));
        chk("busy16", longint'(b16), longint'(ms[1] != 0));
        chk("drop16", longint'(e16), longint'(mdrop[1]));
        if (ms[1] == 2) begin
            chk("data16", longint'(d16), macc[1]);
            chk("ovf16", longint'(o16), longint'(movf[1]));
        end
    endtask

    // Advance one clock: model sees the same inputs the DUTs sample.
    task automatic cyc();
        mstep(0);
        mstep(1);
        @(posedge clk);
        #1;
        mcompare();
    endtask

    task automatic start_run(int l);
        start = 1'b1;
        len = 8'(l);
        cyc();
        start = 1'b0;
    endtask

    task automatic feed(int p);
        vld = 1'b1;
        data = 16'(p);
        cyc();
        vld = 1'b0;
    endtask

    task automatic drain();
        rdy = 1'b1;
        cyc();
        rdy = 1'b0;
    endtask

    task automatic addv(int l, int p0, int p1, int p2, int p3,
                        longint e24, bit o24, longint e16, bit o16);
        vec_t v;
        v.l = l;
        v.p[0] = p0; v.p[1] = p1; v.p[2] = p2; v.p[3] = p3;
        v.e24 = e24; v.o24 = o24; v.e16 = e16; v.o16 = o16;
        vq.push_back(v);
    endtask

    initial begin
        mmax[0] = 64'd16777215;
        mmax[1] = 64'd65535;
        mreset();

        addv(4, 3, 5, 7, 9, 24, 0, 24, 0);
        addv(2, 'hF000, 'h2000, 0, 0, 'h11000, 0, 'hFFFF, 1);
        addv(2, 1, 1, 0, 0, 2, 0, 2, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        addv(3, 'hFFFF, 1, 'h100, 0, 'h10100, 0, 'hFFFF, 1);
        addv(1, 'hFFFF, 0, 0, 0, 'hFFFF, 0, 'hFFFF, 0);
        addv(2, 'hFFFF, 0, 0, 0, 'hFFFF, 0, 'hFFFF, 0);

        // Reset state.
        #1;
        chk("rst_vld", longint'(v24), 0);
        chk("rst_data", longint'(d24), 0);
        chk("rst_ovf", longint'(o24), 0);
        chk("rst_busy", longint'(b24), 0);
        chk("rst_drop", longint'(e24), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Vector table.
        foreach (vq[k]) begin
            start_run(vq[k].l);
            for (int j = 0; j < vq[k].l; j++) feed(vq[k].p[j]);
            chk($sformatf("tv%0d_vld", k), longint'(v24), 1);
            chk($sformatf("tv%0d_d24", k), longint'(d24), vq[k].e24);
            chk($sformatf("tv%0d_o24", k), longint'(o24), longint'(vq[k].o24));
            chk($sformatf("tv%0d_d16", k), longint'(d16), vq[k].e16);
            chk($sformatf("tv%0d_o16", k), longint'(o16), longint'(vq[k].o16));
            drain();
            chk($sformatf("tv%0d_idle", k), longint'(b24), 0);
        end

        // Stalls and backpressure.
        start_run(3);
        feed('hFFFF);
        cyc();
        cyc();
        feed(1);
        feed('h100);
        for (int j = 0; j < 5; j++) begin
            chk("bp_vld", longint'(v24), 1);
            chk("bp_data", longint'(d24), 'h10100);
            cyc();
        end
        chk("bp_hold", longint'(v24), 1);
        drain();
        chk("bp_done", longint'(v24), 0);

        // Zero length then back-to-back start.
        start_run(0);
        chk("zl_vld", longint'(v24), 1);
        chk("zl_data", longint'(d24), 0);
        rdy = 1'b1;
        start = 1'b1;
        len = 8'd2;
        cyc();
        rdy = 1'b0;
        start = 1'b0;
        chk("b2b_busy", longint'(b24), 1);
        chk("b2b_vld", longint'(v24), 0);
        feed(10);
        feed(20);
        chk("b2b_res_vld", longint'(v24), 1);
        chk("b2b_res", longint'(d24), 30);
        drain();

        // Product in IDLE.
        feed(77);
        chk("drop_hi", longint'(e24), 1);
        cyc();
        chk("drop_lo", longint'(e24), 0);
        start_run(1);
        feed(5);
        chk("drop_res", longint'(d24), 5);
        drain();

        // Start while accumulating is ignored.
        start_run(2);
        feed(4);
        start = 1'b1;
        len = 8'd5;
        cyc();
        start = 1'b0;
        chk("ign_drop", longint'(e24), 0);
        feed(6);
        chk("ign_vld", longint'(v24), 1);
        chk("ign_res", longint'(d24), 10);
        drain();

        // Abort mid-run.
        start_run(4);
        feed(1);
        feed(2);
        clr = 1'b1;
        vld = 1'b1;
        data = 16'd9;
        cyc();
        clr = 1'b0;
        vld = 1'b0;
        chk("clr_busy", longint'(b24), 0);
        chk("clr_vld", longint'(v24), 0);
        cyc();
        chk("clr_nodrop", longint'(e24), 0);
        start_run(2);
        feed(1);
        feed(2);
        chk("clr_res", longint'(d24), 3);
        drain();

        // Asynchronous reset while a result is pending.
        start_run(0);
        chk("rd_pre", longint'(v24), 1);
        rst_n = 1'b0;
        #1;
        chk("rd_vld", longint'(v24), 0);
        chk("rd_busy", longint'(b24), 0);
        chk("rd_vld16", longint'(v16), 0);
        mreset();
        #2;
        rst_n = 1'b1;
        cyc();

        // Random traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 3) == 0);
            len = 8'($urandom_range(0, 6));
            clr = ($urandom_range(0, 40) == 0);
            vld = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 2) == 0)
                data = 16'hFFFF - 16'($urandom_range(0, 3));
            else
                data = 16'($urandom);
            rdy = ($urandom_range(0, 1) == 1);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
